// File: rtl/mul_div_pkg.sv
`default_nettype none
// ============================================================================
//  mul_div_pkg
//  Shared funct3 and FSM state encodings for the iterative RV32M unit.
//  Revision: 1.0
// ============================================================================
package mul_div_pkg;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mul_div_step.sv
`default_nettype none
// ============================================================================
//  mul_div_step
//  One shift-add multiply or restoring-divide iteration on {hi, lo}.
//  Revision: 1.0
// ============================================================================
module mul_div_step #(
    parameter int WIDTH = 32
) (
    input  logic             i_is_div,
    input  logic [WIDTH-1:0] i_hi,
    input  logic [WIDTH-1:0] i_lo,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH-1:0] w_diff;

    always_comb begin
        w_sum   = {1'b0, i_hi} + {1'b0, {WIDTH{i_lo[0]}} & i_b};
        w_shift = {i_hi, i_lo[WIDTH-1]};
        // Partial remainder stays below the divisor, so W bits hold the difference.
        w_diff  = w_shift[WIDTH-1:0] - i_b;
        if (i_is_div) begin
            if (w_shift >= {1'b0, i_b}) begin
                o_hi = w_diff;
                o_lo = {i_lo[WIDTH-2:0], 1'b1};
            end else begin
                o_hi = w_shift[WIDTH-1:0];
                o_lo = {i_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            o_hi = w_sum[WIDTH:1];
            o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
//  mul_div_unit
//  Iterative RV32M multiply/divide with start/busy/done handshake.
//  Revision: 1.0
// ============================================================================
module mul_div_unit
    import mul_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    localparam int c_CW = $clog2(WIDTH + 1);

    logic [1:0]       r_state;
    logic [c_CW-1:0]  r_count;
    logic [2:0]       r_op;
    logic             r_neg;
    logic             r_special;
    logic [WIDTH-1:0] r_special_val;
    logic [WIDTH-1:0] r_hi, r_lo, r_b;
    logic             r_busy, r_done;
    logic [WIDTH-1:0] r_result;

    logic             w_is_div, w_neg1, w_neg2, w_div0, w_ovf;
    logic [WIDTH-1:0] w_mag1, w_mag2, w_special_val;
    logic [WIDTH-1:0] w_hi_nxt, w_lo_nxt, w_final;
    logic [2*WIDTH-1:0] w_prod;

    mul_div_step #(.WIDTH(WIDTH)) u_step (
        .i_is_div (r_op[2]),
        .i_hi     (r_hi),
        .i_lo     (r_lo),
        .i_b      (r_b),
        .o_hi     (w_hi_nxt),
        .o_lo     (w_lo_nxt)
    );

    // Operand decode, evaluated at the accepting edge only.
    always_comb begin
        w_is_div = funct3[2];
        w_neg1   = operand1[WIDTH-1] & (funct3 == FUNCT3_MULH || funct3 == FUNCT3_MULHSU ||
                                        funct3 == FUNCT3_DIV  || funct3 == FUNCT3_REM);
        w_neg2   = operand2[WIDTH-1] & (funct3 == FUNCT3_MULH || funct3 == FUNCT3_DIV ||
                                        funct3 == FUNCT3_REM);
        w_mag1   = w_neg1 ? -operand1 : operand1;
        w_mag2   = w_neg2 ? -operand2 : operand2;
        w_div0   = w_is_div && (operand2 == '0);
        w_ovf    = (funct3 == FUNCT3_DIV || funct3 == FUNCT3_REM) &&
                   (operand1 == {1'b1, {(WIDTH-1){1'b0}}}) && (operand2 == '1);
        if (w_div0)
            w_special_val = funct3[1] ? operand1 : '1;
        else
            w_special_val = (funct3 == FUNCT3_DIV) ? operand1 : '0;
    end

    always_comb begin
        w_prod = {w_hi_nxt, w_lo_nxt};
        if (r_neg)
            w_prod = -w_prod;
        if (r_special)
            w_final = r_special_val;
        else if (r_op == FUNCT3_MUL)
            w_final = w_prod[WIDTH-1:0];
        else if (!r_op[2])
            w_final = w_prod[2*WIDTH-1:WIDTH];
        else if (r_op[1])
            w_final = r_neg ? -w_hi_nxt : w_hi_nxt;
        else
            w_final = r_neg ? -w_lo_nxt : w_lo_nxt;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_count       <= '0;
            r_op          <= '0;
            r_neg         <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_b           <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_result      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state       <= ST_RUN;
                        r_busy        <= 1'b1;
                        r_count       <= c_CW'(WIDTH);
                        r_op          <= funct3;
                        r_neg         <= (funct3 == FUNCT3_REM) ? w_neg1 : (w_neg1 ^ w_neg2);
                        r_special     <= w_div0 | w_ovf;
                        r_special_val <= w_special_val;
                        r_hi          <= '0;
                        r_lo          <= w_is_div ? w_mag1 : w_mag2;
                        r_b           <= w_is_div ? w_mag2 : w_mag1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_hi    <= w_hi_nxt;
                    r_lo    <= w_lo_nxt;
                    r_count <= r_count - c_CW'(1);
                    if (r_count == c_CW'(1)) begin
                        r_result <= w_final;
                        r_state  <= ST_DONE;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign result = r_result;
    assign zero   = (r_result == '0);

endmodule
`default_nettype wire
